// File: rtl/count_uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : count_uart_pkg
// Brief   : Shared types and constants for the count UART transmitter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package count_uart_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Start + 8 data + stop
    localparam int FRAME_BITS = 10;

endpackage

`default_nettype wire

// File: rtl/count_uart_fifo.sv
//------------------------------------------------------------------------------
// Module  : count_uart_fifo
// Brief   : Small synchronous FIFO with a combinational head read, so a pop
//           and the consumer's load of the head entry share one clock edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Occupancy update: push+pop together leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since only written slots are read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and count; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_uart_tx.sv
//------------------------------------------------------------------------------
// Module  : count_uart_tx
// Brief   : 8N1 LSB-first UART transmitter fed by a small byte FIFO over a
//           valid/ready handshake. Frames run back-to-back while data waits.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    import count_uart_pkg::*;

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(FRAME_BITS - 3);

    uart_state_e   state_q;
    uart_state_e   state_d;
    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_idx_q;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shreg_q;
    logic [7:0]    shreg_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic          push;
    logic          pop;
    logic          baud_last;

    count_uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign in_ready  = !fifo_full;
    assign push      = in_valid && !fifo_full;
    assign baud_last = (baud_q == BAUD_LAST);

    // A new byte is taken either from idle or on the final stop cycle, which
    // is what lets consecutive frames abut with no idle gap
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));

    // Next-state logic for FSM, baud counter, bit index and shift register
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = ST_START;
                    shreg_d = fifo_rdata;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (pop) begin
                        state_d = ST_START;
                        shreg_d = fifo_rdata;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    // Line driver: decoded from registered state only, so it is glitch-free
    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg_q[0];
            default:  tx = 1'b1;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/count_uart_tx.md
# count_uart_tx

Byte-stream UART transmitter (8N1, LSB first) with a small input FIFO. It is the outbound end of the counter design: it takes 8-bit count values over a valid/ready handshake and serialises them on one output pin, so count streams can be read off-chip by a host UART receiver. It sits between the counter datapath and a dedicated output pin (uo_out[0] in the top wrapper).

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be ≥2.
- DEPTH, 4: FIFO entries. Power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte; equals !full.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (start through stop).
- level  output  $clog2(DEPTH)+1  number of bytes currently in the FIFO.

## Operation
- Push: a byte is accepted on a rising edge where in_valid && in_ready. in_ready depends only on FIFO state, never on in_valid. When the FIFO is full, in_ready=0 even if a pop occurs in the same cycle.
- Pop: the FSM pops the FIFO head when it is in IDLE with level≠0, or in the last cycle of STOP with level≠0.
- The FSM has four states:
  - IDLE: tx=1, busy=0. Moves to START on pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA: shifts out 8 bits LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts bits; after bit 7 it goes to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. It then goes to START if it popped, otherwise to IDLE.
- Shift register: loaded with the popped byte on the pop edge; shifts right at each bit boundary.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps, and clears on every state entry.
- level: +1 on push only, −1 on pop only, unchanged on push+pop. It never exceeds DEPTH and never underflows.
- FIFO pointers: $clog2(DEPTH) bits each; wrap naturally.
- Reset values: tx=1, busy=0, in_ready=1, level=0, FSM=IDLE, pointers=0, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame. tx returns high on the reset edge and the FIFO contents are discarded.
- Ports carry no X: tx must never be X after the first reset edge.

## Timing
- Latency: byte accepted at edge k into an empty FIFO with the FSM in IDLE. The pop happens at edge k+1, and tx=0 and busy=1 are visible after edge k+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles from tx falling to the end of the stop bit.
- Back-to-back: with data queued, the next start bit follows the last stop cycle directly, with zero idle cycles. busy stays high across frames.
- A push into a full FIFO is not accepted, and the upstream must hold the byte.
- in_ready rises the cycle after the pop that frees a slot.

## Structure
- Package count_uart_pkg:
  - typedef enum of the FSM states {IDLE, START, DATA, STOP}.
  - localparam FRAME_BITS=10.
  - function clog2 helper, if the toolchain needs one.
- Sub-module count_uart_fifo: synchronous FIFO, parameterised on DEPTH and WIDTH=8.
  - Ports: clk, rst, push, pop, wdata, rdata, full, empty, level.
  - rdata is combinational from the head entry, so a pop and the shift-register load occur on the same edge.
- The top contains the FSM, baud counter, bit index and shift register.

## Test plan
- Reset: hold rst=1 for 2 cycles → tx=1, busy=0, in_ready=1, level=0. Assert rst mid-frame → tx=1 on the next edge, level=0.
- Single byte 0x55, CLKS_PER_BIT=16 → tx bits 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 16 cycles wide. tx falls 1 cycle after acceptance; busy is high for 160 cycles.
- Back-to-back 0xA3 then 0x0F pushed on consecutive cycles → two frames with no idle gap. Sampling at bit centres decodes 0xA3 then 0x0F; busy never drops between the frames.
- Fill: hold in_valid=1 with 0x00..0x05 → the first 5 bytes are accepted (1 popped immediately, 4 queued); in_ready=0 with level=4. The sixth byte is accepted exactly 1 cycle after the second pop; the output order is 0x00..0x05.
- Simultaneous push/pop at the end of a stop bit with level=2 → level stays 2; the next start bit begins with no gap.
- Random: 200 random bytes with random in_valid gaps → a bit-centre sampling model decodes an identical sequence, level stays within 0..DEPTH, and tx is never X.
